mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_access_unit_load_extend.sv | 48 ++++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Parametros (package)
// Description : Shared definitions for the memory access unit: FSM state
//               encoding, funct3 access-size codes, reset PC constant and
//               the access legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package Parametros;

    // Memory access unit FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2,
        RESP      = 2'd3
    } state_t;

    // funct3 access-size codes (stores reuse B/H/W)
    localparam logic [2:0] c_F3_B  = 3'd0;
    localparam logic [2:0] c_F3_H  = 3'd1;
    localparam logic [2:0] c_F3_W  = 3'd2;
    localparam logic [2:0] c_F3_BU = 3'd4;
    localparam logic [2:0] c_F3_HU = 3'd5;

    // Core reset program counter
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // Returns 1 for a misaligned or illegal access.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (funct3)
            c_F3_B:  fault = 1'b0;
            c_F3_H:  fault = addr_lo[0];
            c_F3_W:  fault = (addr_lo != 2'b00);
            c_F3_BU: fault = we;                  // no unsigned store form
            c_F3_HU: fault = we | addr_lo[0];
            default: fault = 1'b1;                // funct3 3, 6, 7
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load-data extractor. Selects the byte or half
//               addressed by addr_lo from the RAM word and sign- or
//               zero-extends it according to funct3.
// Ports       : funct3  - access size code
//               addr_lo - byte offset within the word
//               word    - raw RAM word
//               result  - extended 32-bit load value (0 for unknown codes)
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import Parametros::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr_lo)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        // Halves are only ever accessed at even offsets, so bit 1 selects.
        w_half = addr_lo[1] ? word[31:16] : word[15:0];

        result = 32'h0000_0000;
        case (funct3)
            c_F3_B:  result = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  result = {{16{w_half[15]}}, w_half};
            c_F3_W:  result = word;
            c_F3_BU: result = {24'h00_0000, w_byte};
            c_F3_HU: result = {16'h0000, w_half};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : CPU load/store unit in front of a fixed-latency synchronous
//               RAM. Accepts one request at a time, checks alignment and
//               legality, performs the RAM read or byte-lane write and
//               returns a one-cycle response pulse.
// Ports       : clockCPU, reset (async, active-high)
//               req_*       - request handshake / payload from the CPU
//               rsp_*       - response pulse, extended load data, error flag
//               ram_*       - RAM address, write data, lanes, enables, read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import Parametros::*;
#(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 10
)
(
    input  logic                 clockCPU,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [2:0]           req_funct3,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic [31:0]          ram_data,
    output logic [3:0]           ram_byteena,
    output logic                 ram_wren,
    output logic                 ram_rden,
    input  logic [31:0]          ram_q
);

    // Counter value seen on the final READ_WAIT edge
    localparam logic [2:0] c_LAST_CNT = 3'(LATENCY - 1);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_rsp_valid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [ADDR_BITS-1:0]  r_ram_address;
    logic [31:0]           r_ram_data;
    logic [3:0]            r_byteena;
    logic                  r_wren;
    logic                  r_rden;

    logic                  w_fault;
    logic [31:0]           w_store_data;
    logic [3:0]            w_store_be;
    logic [31:0]           w_load_result;
    logic                  w_unused_addr;

    // Upper address bits above the RAM window are intentionally ignored.
    assign w_unused_addr = &{1'b0, req_addr};

    assign w_fault = access_fault(req_we, req_funct3, req_addr[1:0]);

    // Store lane replication and byte enables from the live request
    always_comb begin
        w_store_data = req_wdata;
        w_store_be   = 4'b1111;
        case (req_funct3)
            c_F3_B: begin
                w_store_data = {4{req_wdata[7:0]}};
                w_store_be   = 4'b0001 << req_addr[1:0];
            end
            c_F3_H: begin
                w_store_data = {2{req_wdata[15:0]}};
                w_store_be   = 4'b0011 << req_addr[1:0];
            end
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .word    (ram_q),
        .result  (w_load_result)
    );

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= 3'd0;
            r_funct3      <= 3'd0;
            r_addr_lo     <= 2'd0;
            r_rsp_valid   <= 1'b0;
            r_rdata       <= 32'h0000_0000;
            r_err         <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= 32'h0000_0000;
            r_byteena     <= 4'b0000;
            r_wren        <= 1'b0;
            r_rden        <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_cnt     <= 3'd0;
                        if (w_fault) begin
                            // Response fields change only when a response starts.
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                            r_rdata     <= 32'h0000_0000;
                        end else begin
                            r_ram_address <= req_addr[ADDR_BITS+1:2];
                            if (req_we) begin
                                r_state    <= WRITE;
                                r_wren     <= 1'b1;
                                r_byteena  <= w_store_be;
                                r_ram_data <= w_store_data;
                            end else begin
                                r_state <= READ_WAIT;
                                r_rden  <= 1'b1;
                            end
                        end
                    end
                end
                READ_WAIT: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_state     <= RESP;
                        r_rden      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_load_result;
                        r_err       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                WRITE: begin
                    r_state     <= RESP;
                    r_wren      <= 1'b0;
                    r_byteena   <= 4'b0000;
                    r_rsp_valid <= 1'b1;
                    r_rdata     <= 32'h0000_0000;
                    r_err       <= 1'b0;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_byteena = r_byteena;
    assign ram_wren    = r_wren;
    assign ram_rden    = r_rden;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               small RAM model of read latency 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clockCPU;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_q;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:15];

    mem_access_unit #(.LATENCY(2), .ADDR_BITS(10)) dut (
        .clockCPU    (clockCPU),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_funct3  (req_funct3),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_byteena (ram_byteena),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    initial clockCPU = 1'b0;
    always #5 clockCPU = ~clockCPU;

    // RAM model: data appears one edge after a read-enabled edge, so it is
    // valid in the second rden cycle (latency 2); garbage otherwise.
    always @(posedge clockCPU) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
            mem[1] <= 32'h1122_3344;
            mem[2] <= 32'h8899_AABB;
            ram_q  <= 32'hDEAD_BEEF;
        end else begin
            ram_q <= ram_rden ? mem[ram_address[3:0]] : 32'hDEAD_BEEF;
            if (ram_wren)
                for (int i = 0; i < 4; i++)
                    if (ram_byteena[i]) mem[ram_address[3:0]][8*i +: 8] <= ram_data[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request in IDLE and follows it to the rsp_valid cycle.
    // lat counts cycles after the accept edge; returns at the response cycle.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int n_wr, output int n_rd,
                           output logic [3:0] be_seen, output logic [31:0] data_seen,
                           output logic [9:0] addr_seen);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clockCPU);
        // Disturb the inputs while the access is in flight.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = ~wdata;
        lat = 1; n_wr = 0; n_rd = 0;
        be_seen = 4'h0; data_seen = 32'h0; addr_seen = 10'h0;
        while (!rsp_valid && lat < 20) begin
            if (ram_wren) begin n_wr++; be_seen = ram_byteena; data_seen = ram_data; end
            if (ram_rden) begin n_rd++; addr_seen = ram_address; end
            @(negedge clockCPU);
            lat++;
        end
    endtask

    int          lat, n_wr, n_rd, seen;
    logic [3:0]  be_s;
    logic [31:0] data_s;
    logic [9:0]  addr_s;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'd0;
        repeat (2) @(negedge clockCPU);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_rden", ram_rden, 0);
        check("rst_ram_address", ram_address, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_ram_byteena", ram_byteena, 0);
        reset = 1'b0;
        @(negedge clockCPU);

        // LW 0x8
        run_req(1'b0, 3'd2, 32'h0000_0008, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lw_latency", lat, 3);
        check("lw_rden_cycles", n_rd, 2);
        check("lw_ram_address", addr_s, 10'd2);
        check("lw_rdata", rsp_rdata, 32'h8899_AABB);
        check("lw_err", rsp_err, 0);
        @(negedge clockCPU);
        check("lw_pulse_one_cycle", rsp_valid, 0);
        check("lw_rdata_stable", rsp_rdata, 32'h8899_AABB);
        check("lw_ready_after", req_ready, 1);
        check("lw_address_held", ram_address, 10'd2);

        // Byte / half loads with extension
        run_req(1'b0, 3'd0, 32'h0000_000B, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lb_rdata", rsp_rdata, 32'hFFFF_FF88);
        @(negedge clockCPU);
        run_req(1'b0, 3'd4, 32'h0000_000B, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lbu_rdata", rsp_rdata, 32'h0000_0088);
        @(negedge clockCPU);
        run_req(1'b0, 3'd1, 32'h0000_000A, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lh_rdata", rsp_rdata, 32'hFFFF_8899);
        @(negedge clockCPU);
        run_req(1'b0, 3'd5, 32'h0000_0008, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lhu_low_rdata", rsp_rdata, 32'h0000_AABB);
        check("lhu_latency", lat, 3);
        @(negedge clockCPU);

        // SB 0x5
        run_req(1'b1, 3'd0, 32'h0000_0005, 32'h0000_00C3, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("sb_latency", lat, 2);
        check("sb_wren_cycles", n_wr, 1);
        check("sb_rden_cycles", n_rd, 0);
        check("sb_byteena", be_s, 4'b0010);
        check("sb_ram_data", data_s, 32'hC3C3_C3C3);
        check("sb_rdata", rsp_rdata, 0);
        check("sb_err", rsp_err, 0);
        check("sb_byteena_resp", ram_byteena, 4'b0000);
        check("sb_address_held", ram_address, 10'd1);
        @(negedge clockCPU);
        run_req(1'b0, 3'd2, 32'h0000_0004, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lw_after_sb", rsp_rdata, 32'h1122_C344);
        @(negedge clockCPU);

        // SH 0x6 (upper half)
        run_req(1'b1, 3'd1, 32'h0000_0006, 32'hABCD_1234, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("sh_byteena", be_s, 4'b1100);
        check("sh_ram_data", data_s, 32'h1234_1234);
        check("sh_latency", lat, 2);
        @(negedge clockCPU);

        // Misaligned / illegal
        run_req(1'b1, 3'd2, 32'h0000_0006, 32'h5555_5555, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("sw_mis_latency", lat, 1);
        check("sw_mis_err", rsp_err, 1);
        check("sw_mis_wren", n_wr, 0);
        check("sw_mis_rdata", rsp_rdata, 0);
        @(negedge clockCPU);
        check("err_stable", rsp_err, 1);
        run_req(1'b0, 3'd1, 32'h0000_0003, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("lh_mis_latency", lat, 1);
        check("lh_mis_err", rsp_err, 1);
        check("lh_mis_rden", n_rd, 0);
        @(negedge clockCPU);
        run_req(1'b0, 3'd3, 32'h0000_0000, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("f3_3_err", rsp_err, 1);
        @(negedge clockCPU);
        run_req(1'b1, 3'd4, 32'h0000_0000, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("sbu_illegal_err", rsp_err, 1);
        check("sbu_illegal_wren", n_wr, 0);
        @(negedge clockCPU);
        run_req(1'b0, 3'd2, 32'h0000_0008, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("err_cleared_by_load", rsp_err, 0);
        @(negedge clockCPU);

        // Back-to-back: LW held valid through RESP
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0008;
        repeat (3) @(negedge clockCPU);
        check("b2b_first_rsp", rsp_valid, 1);
        @(negedge clockCPU);
        check("b2b_idle_ready", req_ready, 1);
        @(negedge clockCPU);
        check("b2b_second_accept", ram_rden, 1);
        check("b2b_second_busy", req_ready, 0);
        req_valid = 1'b0;
        repeat (2) @(negedge clockCPU);
        check("b2b_second_rsp", rsp_valid, 1);
        check("b2b_second_rdata", rsp_rdata, 32'h8899_AABB);
        @(negedge clockCPU);

        // Reset during READ_WAIT cycle 1
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0008;
        @(negedge clockCPU);
        req_valid = 1'b0;
        check("rstmid_in_read", ram_rden, 1);
        reset = 1'b1;
        #1;
        check("rstmid_rden", ram_rden, 0);
        check("rstmid_ready", req_ready, 1);
        check("rstmid_rsp_valid", rsp_valid, 0);
        @(negedge clockCPU);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clockCPU);
            if (rsp_valid) seen++;
        end
        check("rstmid_no_response", seen, 0);
        run_req(1'b0, 3'd2, 32'h0000_0008, 32'h0, lat, n_wr, n_rd, be_s, data_s, addr_s);
        check("post_rst_lw_latency", lat, 3);
        check("post_rst_lw_rdata", rsp_rdata, 32'h8899_AABB);
        @(negedge clockCPU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
